// File: rtl/fsm_stim_sched_pkg.sv
// Shared types and default sizing for the FSM stimulus scheduler.
package fsm_stim_pkg;

  localparam int unsigned DEF_NSEG  = 8;
  localparam int unsigned DEF_LEN_W = 8;
  localparam int unsigned DEF_CNT_W = 16;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  typedef struct packed {
    logic                 level;
    logic [DEF_LEN_W-1:0] len;
  } seg_t;

endpackage

// File: rtl/fsm_stim_sched_if.sv
// Control, status and FSM-observation signals of the stimulus scheduler.
interface fsm_stim_sched_if #(
  parameter int unsigned NSEG  = 8,
  parameter int unsigned LEN_W = 8,
  parameter int unsigned CNT_W = 16
) ();
  localparam int unsigned AW = $clog2(NSEG);

  logic             cfg_we;
  logic [AW-1:0]    cfg_addr;
  logic             cfg_level;
  logic [LEN_W-1:0] cfg_len;
  logic [AW:0]      num_seg;
  logic             loop_en;
  logic             start;
  logic             abort;
  logic             y1;
  logic             y2;
  logic             x;
  logic             busy;
  logic             done;
  logic [AW-1:0]    seg_idx;
  logic [CNT_W-1:0] y1_cnt;
  logic [CNT_W-1:0] y2_cnt;

  modport master (
    output cfg_we, cfg_addr, cfg_level, cfg_len, num_seg, loop_en, start, abort, y1, y2,
    input  x, busy, done, seg_idx, y1_cnt, y2_cnt
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_level, cfg_len, num_seg, loop_en, start, abort, y1, y2,
    output x, busy, done, seg_idx, y1_cnt, y2_cnt
  );
endinterface

// File: rtl/fsm_stim_sched_edge_counter.sv
// Registered rising-edge detector feeding a saturating counter with clear/enable.
module edge_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic             d_i,
  output logic [CNT_W-1:0] cnt_o
);
  logic             samp_q, prev_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && samp_q && !prev_q && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // On clear the history is seeded with the live input so a level already high does not count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      samp_q <= 1'b0;
      prev_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      samp_q <= d_i;
      prev_q <= clr_i ? d_i : samp_q;
      cnt_q  <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
endmodule

// File: rtl/fsm_stim_sched.sv
// Table-driven (level, duration) sequencer for the FSM serial input x, with y1/y2 edge counting.
module fsm_stim_sched
  import fsm_stim_pkg::*;
#(
  parameter int unsigned NSEG  = DEF_NSEG,
  parameter int unsigned LEN_W = DEF_LEN_W,
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input logic             clock,
  input logic             reset_n,
  fsm_stim_sched_if.slave bus
);
  localparam int unsigned AW = $clog2(NSEG);
  localparam int unsigned NW = AW + 1;

  typedef struct packed {
    logic             level;
    logic [LEN_W-1:0] len;
  } entry_t;

  entry_t           tbl_q [NSEG];
  state_t           state_q, state_d;
  logic             x_q, x_d;
  logic [AW-1:0]    seg_q, seg_d, seg_nxt;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [NW-1:0]    nseg_q, nseg_d;
  logic             loop_q, loop_d;
  logic             done_q;
  logic             start_ok, last_seg, run_clr, run_en;

  function automatic logic [LEN_W-1:0] eff_len(input logic [LEN_W-1:0] len);
    return (len == '0) ? LEN_W'(1) : len;
  endfunction

  assign start_ok = bus.start && (bus.num_seg != '0) && (bus.num_seg <= NW'(NSEG));
  assign last_seg = ({1'b0, seg_q} == (nseg_q - NW'(1)));
  assign seg_nxt  = last_seg ? '0 : seg_q + AW'(1);
  assign run_en   = (state_q == S_RUN);

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    seg_d   = seg_q;
    cnt_d   = cnt_q;
    nseg_d  = nseg_q;
    loop_d  = loop_q;
    run_clr = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start_ok) begin
          run_clr = 1'b1;
          nseg_d  = bus.num_seg;
          loop_d  = bus.loop_en;
          seg_d   = '0;
          cnt_d   = eff_len(tbl_q[0].len);
          x_d     = tbl_q[0].level;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        // Abort wins over the segment-end advance; the down-counter reaching 1 marks the last cycle
        if (bus.abort) begin
          state_d = S_IDLE;
          x_d     = 1'b0;
        end else if (cnt_q == LEN_W'(1)) begin
          if (last_seg && !loop_q) begin
            state_d = S_DONE;
            x_d     = 1'b0;
          end else begin
            seg_d = seg_nxt;
            cnt_d = eff_len(tbl_q[seg_nxt].len);
            x_d   = tbl_q[seg_nxt].level;
          end
        end else begin
          cnt_d = cnt_q - LEN_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      x_q     <= 1'b0;
      seg_q   <= '0;
      cnt_q   <= '0;
      nseg_q  <= '0;
      loop_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      seg_q   <= seg_d;
      cnt_q   <= cnt_d;
      nseg_q  <= nseg_d;
      loop_q  <= loop_d;
      done_q  <= (state_q == S_DONE);
    end
  end

  always_ff @(posedge clock) begin
    if (bus.cfg_we && (state_q == S_IDLE)) begin
      tbl_q[bus.cfg_addr] <= {bus.cfg_level, bus.cfg_len};
    end
  end

  edge_counter #(.CNT_W(CNT_W)) u_y1_cnt (
    .clk   (clock),
    .rst_n (reset_n),
    .clr_i (run_clr),
    .en_i  (run_en),
    .d_i   (bus.y1),
    .cnt_o (bus.y1_cnt)
  );

  edge_counter #(.CNT_W(CNT_W)) u_y2_cnt (
    .clk   (clock),
    .rst_n (reset_n),
    .clr_i (run_clr),
    .en_i  (run_en),
    .d_i   (bus.y2),
    .cnt_o (bus.y2_cnt)
  );

  assign bus.x       = x_q;
  assign bus.busy    = run_en;
  assign bus.done    = done_q;
  assign bus.seg_idx = seg_q;
endmodule

// File: tb/tb_fsm_stim_sched.sv
// Scenario table + scoreboard bench for fsm_stim_sched, with hand sequences for counters and reset.
module tb_fsm_stim_sched;
  import fsm_stim_pkg::*;

  localparam int NSEG = 8;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  fsm_stim_sched_if #(.NSEG(8), .LEN_W(8), .CNT_W(16)) ifa ();
  fsm_stim_sched_if #(.NSEG(8), .LEN_W(8), .CNT_W(4))  ifb ();

  fsm_stim_sched #(.NSEG(8), .LEN_W(8), .CNT_W(16)) dut_a (
    .clock(clock), .reset_n(reset_n), .bus(ifa.slave)
  );
  fsm_stim_sched #(.NSEG(8), .LEN_W(8), .CNT_W(4)) dut_b (
    .clock(clock), .reset_n(reset_n), .bus(ifb.slave)
  );

  typedef struct packed {
    logic       x;
    logic       busy;
    logic       done;
    logic [2:0] seg;
  } exp_t;

  typedef struct {
    string          name;
    int             nw;
    seg_t [3:0]     segs;
    int             n;
    bit             loop;
    int             ncyc;
    int             abort_at;
    int             wp_at;
  } scen_t;

  int         n_cmp = 0;
  int         n_bad = 0;
  exp_t       sbq[$];
  seg_t       mtab[NSEG];
  logic [2:0] mlast = 3'd0;
  scen_t      sc[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clock);
    #1;
  endtask

  function automatic exp_t mk(input logic x, input logic b, input logic d, input logic [2:0] s);
    exp_t e;
    e.x = x; e.busy = b; e.done = d; e.seg = s;
    return e;
  endfunction

  function automatic seg_t sg(input logic lev, input int len);
    seg_t s;
    s.level = lev;
    s.len   = 8'(len);
    return s;
  endfunction

  task automatic cfg_write(input int addr, input seg_t s);
    ifa.cfg_we    = 1'b1;
    ifa.cfg_addr  = 3'(addr);
    ifa.cfg_level = s.level;
    ifa.cfg_len   = s.len;
    tick();
    ifa.cfg_we    = 1'b0;
    mtab[addr]    = s;
  endtask

  task automatic set_scen(input int i, input string name, input int nw, input int n, input bit loop,
                          input int ncyc, input int abort_at, input int wp_at);
    sc[i].name = name; sc[i].nw = nw; sc[i].n = n; sc[i].loop = loop;
    sc[i].ncyc = ncyc; sc[i].abort_at = abort_at; sc[i].wp_at = wp_at;
  endtask

  // Expected per-cycle trace for cycles 1..ncyc after the start cycle, from the model table
  task automatic build(input int i);
    int s;
    int len;
    logic [2:0] hold;
    sbq.delete();
    s = 0;
    if (sc[i].n < 1 || sc[i].n > NSEG) begin
      repeat (sc[i].ncyc) sbq.push_back(mk(1'b0, 1'b0, 1'b0, mlast));
    end else begin
      while (sbq.size() < sc[i].ncyc) begin
        len = (mtab[s].len == 8'd0) ? 1 : int'(mtab[s].len);
        repeat (len) sbq.push_back(mk(mtab[s].level, 1'b1, 1'b0, 3'(s)));
        if (s == sc[i].n - 1) begin
          if (sc[i].loop) s = 0;
          else begin
            sbq.push_back(mk(1'b0, 1'b0, 1'b0, 3'(s)));
            sbq.push_back(mk(1'b0, 1'b0, 1'b1, 3'(s)));
            while (sbq.size() < sc[i].ncyc) sbq.push_back(mk(1'b0, 1'b0, 1'b0, 3'(s)));
          end
        end else begin
          s++;
        end
      end
    end
    if (sc[i].abort_at > 0) begin
      hold = sbq[sc[i].abort_at-1].seg;
      for (int k = sc[i].abort_at; k < sc[i].ncyc; k++) sbq[k] = mk(1'b0, 1'b0, 1'b0, hold);
    end
    mlast = sbq[sc[i].ncyc-1].seg;
  endtask

  task automatic run_scen(input int i);
    exp_t e;
    for (int w = 0; w < sc[i].nw; w++) cfg_write(w, sc[i].segs[w]);
    build(i);
    ifa.start   = 1'b1;
    ifa.num_seg = 4'(sc[i].n);
    ifa.loop_en = sc[i].loop;
    for (int c = 1; c <= sc[i].ncyc; c++) begin
      tick();
      ifa.start  = 1'b0;
      ifa.abort  = 1'b0;
      ifa.cfg_we = 1'b0;
      e = sbq.pop_front();
      chk($sformatf("%s c%0d x", sc[i].name, c), 32'(ifa.x), 32'(e.x));
      chk($sformatf("%s c%0d busy", sc[i].name, c), 32'(ifa.busy), 32'(e.busy));
      chk($sformatf("%s c%0d done", sc[i].name, c), 32'(ifa.done), 32'(e.done));
      chk($sformatf("%s c%0d seg", sc[i].name, c), 32'(ifa.seg_idx), 32'(e.seg));
      if (c == sc[i].abort_at) ifa.abort = 1'b1;
      if (c == sc[i].wp_at) begin
        ifa.cfg_we    = 1'b1;
        ifa.cfg_addr  = 3'd0;
        ifa.cfg_level = ~mtab[0].level;
        ifa.cfg_len   = 8'd1;
        ifa.start     = 1'b1;
        ifa.num_seg   = 4'd1;
      end
    end
    ifa.start  = 1'b0;
    ifa.abort  = 1'b0;
    ifa.cfg_we = 1'b0;
  endtask

  initial begin
    {ifa.cfg_we, ifa.cfg_addr, ifa.cfg_level, ifa.cfg_len, ifa.num_seg, ifa.loop_en} = '0;
    {ifa.start, ifa.abort, ifa.y1, ifa.y2} = '0;
    {ifb.cfg_we, ifb.cfg_addr, ifb.cfg_level, ifb.cfg_len, ifb.num_seg, ifb.loop_en} = '0;
    {ifb.start, ifb.abort, ifb.y1, ifb.y2} = '0;

    set_scen(0, "basic",      3, 3, 1'b0, 18, 0, 0);
    sc[0].segs[0] = sg(1'b1, 3); sc[0].segs[1] = sg(1'b0, 4); sc[0].segs[2] = sg(1'b1, 7);
    set_scen(1, "len0",       2, 2, 1'b0, 6, 0, 0);
    sc[1].segs[0] = sg(1'b1, 0); sc[1].segs[1] = sg(1'b0, 2);
    set_scen(2, "nseg0",      0, 0, 1'b0, 6, 0, 0);
    set_scen(3, "nseg9",      0, 9, 1'b1, 6, 0, 0);
    set_scen(4, "loop_abort", 2, 2, 1'b1, 14, 9, 0);
    sc[4].segs[0] = sg(1'b1, 2); sc[4].segs[1] = sg(1'b0, 2);
    set_scen(5, "abort_adv",  0, 2, 1'b1, 12, 8, 0);
    set_scen(6, "wprot",      3, 3, 1'b0, 18, 0, 5);
    sc[6].segs = sc[0].segs;
    set_scen(7, "rerun",      0, 3, 1'b0, 18, 0, 0);

    tick(2);
    chk("reset x",      32'(ifa.x),       32'd0);
    chk("reset busy",   32'(ifa.busy),    32'd0);
    chk("reset done",   32'(ifa.done),    32'd0);
    chk("reset seg",    32'(ifa.seg_idx), 32'd0);
    chk("reset y1_cnt", 32'(ifa.y1_cnt),  32'd0);
    chk("reset y2_cnt", 32'(ifa.y2_cnt),  32'd0);
    reset_n = 1'b1;
    tick();

    for (int i = 0; i < 8; i++) run_scen(i);

    // Edge counting: 5 y1 pulses, y2 high before start then one real rise
    cfg_write(0, sg(1'b1, 2));
    cfg_write(1, sg(1'b0, 2));
    ifa.y2 = 1'b1;
    tick(2);
    ifa.start = 1'b1; ifa.num_seg = 4'd2; ifa.loop_en = 1'b1;
    tick();
    ifa.start = 1'b0;
    for (int p = 0; p < 5; p++) begin
      ifa.y1 = 1'b1; tick();
      ifa.y1 = 1'b0; tick();
    end
    chk("y2 high at start", 32'(ifa.y2_cnt), 32'd0);
    ifa.y2 = 1'b0; tick(2);
    ifa.y2 = 1'b1; tick(4);
    ifa.abort = 1'b1; tick();
    ifa.abort = 1'b0;
    chk("edge abort busy", 32'(ifa.busy), 32'd0);
    chk("y1_cnt 5 pulses", 32'(ifa.y1_cnt), 32'd5);
    chk("y2_cnt one rise", 32'(ifa.y2_cnt), 32'd1);
    ifa.y1 = 1'b1; tick();
    ifa.y1 = 1'b0; tick(3);
    chk("y1_cnt hold idle", 32'(ifa.y1_cnt), 32'd5);
    ifa.y2 = 1'b0;
    ifa.start = 1'b1; ifa.num_seg = 4'd1; ifa.loop_en = 1'b0;
    tick();
    ifa.start = 1'b0;
    chk("y1_cnt cleared", 32'(ifa.y1_cnt), 32'd0);
    chk("y2_cnt cleared", 32'(ifa.y2_cnt), 32'd0);
    tick(5);
    mlast = 3'd0;

    // Saturation on the narrow-counter instance
    ifb.cfg_we = 1'b1; ifb.cfg_addr = 3'd0; ifb.cfg_level = 1'b1; ifb.cfg_len = 8'd200;
    tick();
    ifb.cfg_we = 1'b0;
    ifb.start = 1'b1; ifb.num_seg = 4'd1; ifb.loop_en = 1'b0;
    tick();
    ifb.start = 1'b0;
    for (int p = 0; p < 10; p++) begin
      ifb.y1 = 1'b1; tick();
      ifb.y1 = 1'b0; tick();
    end
    tick();
    chk("sat y1_cnt 10", 32'(ifb.y1_cnt), 32'd10);
    for (int p = 0; p < 9; p++) begin
      ifb.y1 = 1'b1; tick();
      ifb.y1 = 1'b0; tick();
    end
    tick(2);
    chk("sat y1_cnt max", 32'(ifb.y1_cnt), 32'hF);
    chk("sat still busy", 32'(ifb.busy), 32'd1);
    ifb.abort = 1'b1; tick();
    ifb.abort = 1'b0;

    // Asynchronous reset in the middle of a run
    ifa.start = 1'b1; ifa.num_seg = 4'd3; ifa.loop_en = 1'b0;
    tick();
    ifa.start = 1'b0;
    tick(4);
    chk("pre-reset busy", 32'(ifa.busy), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("async rst x",    32'(ifa.x),       32'd0);
    chk("async rst busy", 32'(ifa.busy),    32'd0);
    chk("async rst seg",  32'(ifa.seg_idx), 32'd0);
    tick();
    reset_n = 1'b1;
    tick();
    chk("post-reset busy", 32'(ifa.busy), 32'd0);
    mlast = 3'd0;
    run_scen(7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/fsm_stim_sched.md
Name: fsm_stim_sched

Overview:
- Programmable stimulus scheduler for the lab FSM (`fsm_top`).
- Drives the FSM's serial input `x` from a table of (level, duration) segments, with start/busy/done handshake, optional looping and abort.
- Counts rising edges of the FSM outputs `y1`/`y2` during a run.
- Sits between the FSM and the bench/top-level control, replacing hand-timed delay stimulus with a cycle-exact, reusable sequencer.

Parameters:
- NSEG, 8: segment table depth (power of 2).
- LEN_W, 8: segment duration width in cycles.
- CNT_W, 16: edge-counter width.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- cfg_we  in  1  table write strobe.
- cfg_addr  in  $clog2(NSEG)  table entry index.
- cfg_level  in  1  x level for the entry.
- cfg_len  in  LEN_W  entry duration in cycles; 0 is treated as 1.
- num_seg  in  $clog2(NSEG)+1  active segment count, sampled on start.
- loop_en  in  1  wrap to segment 0 after the last segment; sampled on start.
- start  in  1  single-cycle run request.
- abort  in  1  stop the run immediately.
- y1  in  1  FSM output 1.
- y2  in  1  FSM output 2.
- x  out  1  FSM input stimulus (registered).
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse on normal completion.
- seg_idx  out  $clog2(NSEG)  current segment index.
- y1_cnt  out  CNT_W  y1 rising edges counted during the run.
- y2_cnt  out  CNT_W  y2 rising edges counted during the run.

Behaviour:
- Reset (asynchronous, reset_n=0):
  - Outputs: state=IDLE, x=0, busy=0, done=0, seg_idx=0, y1_cnt=y2_cnt=0.
  - Edge-detect registers = 0.
  - Table contents are not reset; they are undefined until written.
- States: IDLE, RUN, DONE.
- IDLE:
  - cfg_we writes entry cfg_addr.
  - start=1 with num_seg≥1 and num_seg≤NSEG: latch num_seg and loop_en, clear counters, seg_idx=0, load the down-counter with max(len[0],1), x<=level[0], go RUN. x takes the new level one cycle after start.
  - start with num_seg=0 or num_seg>NSEG is ignored: no state change, no done.
- RUN:
  - busy=1; x holds level[seg_idx] for exactly max(len,1) cycles.
  - On the last cycle of a segment: if seg_idx<num_seg-1, advance, reload the counter and update x on the next edge with no gap cycle.
  - Last segment, loop_en=1: wrap to seg_idx=0.
  - Last segment, loop_en=0: go DONE, x<=0.
- DONE: done=1 for one cycle, busy=0, then IDLE.
  - seg_idx and counters hold their final values until the next start.
- abort:
  - Abort in RUN: next state IDLE, x<=0, busy<=0, no done pulse; counters hold.
  - Abort has priority over a segment advance in the same cycle.
  - Abort in IDLE or DONE has no effect.
- Config/start while active:
  - cfg_we while busy or in DONE is ignored; the table is stable during a run.
  - start while busy is ignored.
- Edge counters:
  - y1 and y2 are sampled through one register each.
  - While busy=1, a counter increments when the sampled value is 1 and the previous sample was 0.
  - Counters saturate at all-ones.
  - The edge-detect history resets to the current y value on start, so a level already high at start does not count.
- Simultaneous start and cfg_we in IDLE: the write completes; the run uses the pre-write table value for that entry only if the write addresses segment 0. Benches must not rely on this case.
- Reset mid-run returns immediately to the reset state; the table is retained but considered stale.

Decomposition:
- Shared package `fsm_stim_pkg`:
  - state enum {S_IDLE, S_RUN, S_DONE}.
  - Default NSEG, LEN_W and CNT_W constants.
  - Segment struct {level, len}.
- Sub-module `edge_counter`:
  - Registered sample, rising-edge detect, saturating CNT_W counter with clear and enable.
  - Instantiated twice, for y1 and y2.
- Table storage is a flop array inside the top module.

Test Plan:
- Basic run: table {0:(1,3), 1:(0,4), 2:(1,7)}, num_seg=3, loop_en=0, pulse start at cycle 0.
  - x=1 for cycles 1–3, 0 for 4–7, 1 for 8–14.
  - done pulses at cycle 16; busy falls at cycle 15.
- len=0: entry (1,0) gives x=1 for exactly 1 cycle.
- num_seg=0: start ignored; busy stays 0 and done never asserts.
- Loop wrap: 2 segments (1,2),(0,2), loop_en=1.
  - x toggles every 2 cycles and seg_idx wraps 1→0.
  - abort at cycle 9 gives x=0 and busy=0 at cycle 10, with no done pulse.
- Edge counting:
  - y1 driven with 5 pulses during a run gives y1_cnt=5.
  - y2 held high from before start gives y2_cnt=0.
  - 2^16+3 y1 pulses with CNT_W=16 gives y1_cnt=16'hFFFF.
- Reset and write-protect:
  - reset_n low mid-RUN forces x=0, busy=0 and state IDLE asynchronously.
  - cfg_we during RUN leaves the table unchanged; verify by a rerun.
